cim_arbiter: RTL
================

# cim_arbiter

Round-robin arbiter that shares one CIM tile array (input-write port, start strobe, obuf read address) between up to NUM_REQ layer controllers. Sits between the per-layer ctrl/func blocks and the CIM tile array. Grants ownership for a whole job, not per cycle, so one requester can issue its bit-serial write and start sequences without interleaving. The CIM array sees a single, gated, muxed command stream.

## Interface
- NUM_REQ, 2, number of requesting layer controllers (≥2)
- DATA_SIZE, 8, bit planes per input word
- BUS_WIDTH, 16, CIM input bus width per vertical tile
- V_CIM_TILES, 1, vertical CIM tiles
- ADDR_WIDTH, 4, CIM input-row address width
- OBUF_ADDR_WIDTH, 4, CIM obuf address width
- QUANTUM, 8, max starts per grant when contention exists (used only with macro)
---
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req  in  NUM_REQ  per-requester ownership request (level)
- o_gnt  out  NUM_REQ  one-hot registered grant
- o_req_ready  out  NUM_REQ  o_gnt[k] & i_cim_ready & state==GRANT
- i_we  in  NUM_REQ  per-requester CIM write enable
- i_start  in  NUM_REQ  per-requester CIM start pulse
- i_addr  in  [ADDR_WIDTH-1:0] x NUM_REQ  per-requester row address
- i_data  in  [BUS_WIDTH*V_CIM_TILES-1:0] x [NUM_REQ][DATA_SIZE]  per-requester write data
- i_obuf_addr  in  [OBUF_ADDR_WIDTH-1:0] x NUM_REQ  per-requester obuf read address
- i_cim_ready  in  1  CIM idle
- o_cim_we  out  1  muxed, gated write enable
- o_cim_start  out  1  muxed, gated start pulse
- o_cim_addr  out  ADDR_WIDTH  muxed row address
- o_cim_data  out  [BUS_WIDTH*V_CIM_TILES-1:0] x [DATA_SIZE]  muxed write data
- o_cim_obuf_addr  out  OBUF_ADDR_WIDTH  muxed obuf address
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, GRANT, BUSY.
- IDLE: o_gnt=0. If any i_req and i_cim_ready=1, choose the winner: first set i_req bit scanning upward from ptr, wrapping modulo NUM_REQ. Register o_gnt one-hot and go to GRANT.
- GRANT: CIM outputs are combinational muxes of the owner's inputs. o_cim_we = i_we[owner] & i_cim_ready, and o_cim_start = i_start[owner] & i_cim_ready. Non-owner i_we/i_start are ignored.
  - Owner i_start while i_cim_ready=1: go to BUSY.
  - Otherwise, if i_req[owner]=0: go to IDLE, clear o_gnt, set ptr=owner+1 (mod NUM_REQ).
  - Start and req-drop in the same cycle: start wins and the grant is kept.
- BUSY: o_cim_we=o_cim_start=0. Addr, data and obuf_addr stay muxed from the owner so the owner's func block can read the obuf. The first BUSY cycle ignores i_cim_ready, because the CIM drops ready one cycle after start. From the second cycle, i_cim_ready=1 returns to GRANT. If i_req[owner]=0 at that point, go directly to IDLE with ptr update.
- No owner (IDLE): all CIM outputs are 0.
- ptr is log2(NUM_REQ) bits and reset to 0, so requester 0 wins first under simultaneous requests.

## Timing
- Reset (synchronous): state=IDLE, ptr=0, o_gnt=0, o_req_ready=0, o_busy=0, all CIM outputs 0, start counter 0.
- Grant latency: i_req high at edge N (CIM ready, IDLE) → o_gnt high after edge N+1.
- A new owner is granted at the earliest 1 cycle after release, through IDLE.
- Requester contract: issue i_we/i_start only while o_req_ready=1. Hold i_req until the last obuf read is done.
- rst mid-job: immediate return to reset values. The CIM job in flight is not aborted by this block.

## Configuration
- CIM_ARB_QUANTUM_EN defined:
  - A start counter increments on each owner start and clears on grant change.
  - When the counter reaches QUANTUM, any other i_req is high, and BUSY completes, the grant is revoked: go to IDLE and advance ptr as if the owner had released.
  - The owner sees o_gnt fall and must wait for a re-grant.
- Macro undefined: no counter and no preemption. The grant lasts until the owner drops i_req.

## Test plan
- Reset then i_req=2'b11 → o_gnt=2'b01 one cycle later. On req0 release → o_gnt=0 for 1 cycle, then 2'b10.
- Owner 0 issues 4 writes (addr 0..3) + start; requester 1 toggles i_we → o_cim_we only reflects req0 and o_cim_addr=0,1,2,3. o_cim_start pulses once, then BUSY until i_cim_ready returns.
- i_start and i_req drop in the same cycle → BUSY entered, grant kept until CIM ready, then IDLE.
- i_cim_ready=0 in IDLE with i_req=01 → no grant until ready=1.
- With CIM_ARB_QUANTUM_EN, QUANTUM=2, both requesting → req0 loses grant after its 2nd start completes and req1 is granted. Without the macro → req0 keeps grant.
- rst asserted during BUSY → next cycle o_gnt=0, o_busy=0, all CIM outputs 0.

Source files
------------

// File: rtl/cim_arbiter.sv
// cim_arbiter
// Round-robin, job-granular arbiter that lets up to NUM_REQ layer controllers
// share one CIM tile array. A requester owns the array from grant until it
// drops i_req, so its bit-serial write and start sequence is never
// interleaved with another requester's. The array sees one gated, muxed
// command stream taken from the current owner.
//
// Optional feature: define CIM_ARB_QUANTUM_EN to enable quantum preemption.
// With it, an owner that has issued QUANTUM starts loses the grant when its
// current job completes and another requester is waiting. Without it, the
// grant lasts until the owner releases it.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_req             per-requester ownership request (level)
//   o_gnt             one-hot registered grant
//   o_req_ready       owner may issue i_we/i_start this cycle
//   i_we, i_start     per-requester CIM write enable / start pulse
//   i_addr            per-requester CIM input-row address
//   i_data            per-requester write data, DATA_SIZE bit planes
//   i_obuf_addr       per-requester obuf read address
//   i_cim_ready       CIM array idle
//   o_cim_we          muxed, gated write enable
//   o_cim_start       muxed, gated start pulse
//   o_cim_addr        muxed row address
//   o_cim_data        muxed write data
//   o_cim_obuf_addr   muxed obuf read address
//   o_busy            arbiter holds an owner (not IDLE)

module cim_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int DATA_SIZE       = 8,
    parameter int BUS_WIDTH       = 16,
    parameter int V_CIM_TILES     = 1,
    parameter int ADDR_WIDTH      = 4,
    parameter int OBUF_ADDR_WIDTH = 4,
    parameter int QUANTUM         = 8
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic [NUM_REQ-1:0]                                           i_req,
    output logic [NUM_REQ-1:0]                                           o_gnt,
    output logic [NUM_REQ-1:0]                                           o_req_ready,
    input  logic [NUM_REQ-1:0]                                           i_we,
    input  logic [NUM_REQ-1:0]                                           i_start,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]                           i_addr,
    input  logic [NUM_REQ-1:0][DATA_SIZE-1:0][BUS_WIDTH*V_CIM_TILES-1:0] i_data,
    input  logic [NUM_REQ-1:0][OBUF_ADDR_WIDTH-1:0]                      i_obuf_addr,
    input  logic                                                         i_cim_ready,
    output logic                                                         o_cim_we,
    output logic                                                         o_cim_start,
    output logic [ADDR_WIDTH-1:0]                                        o_cim_addr,
    output logic [DATA_SIZE-1:0][BUS_WIDTH*V_CIM_TILES-1:0]              o_cim_data,
    output logic [OBUF_ADDR_WIDTH-1:0]                                   o_cim_obuf_addr,
    output logic                                                         o_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [IDX_W-1:0]   winner;
    logic               found;
    logic [NUM_REQ-1:0] gnt_n;
    logic               busy_first, busy_first_n;
    logic               revoke;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) return '0;
        else return idx + IDX_W'(1);
    endfunction

`ifdef CIM_ARB_QUANTUM_EN
    localparam int CNT_W = $clog2(QUANTUM + 1);
    logic [CNT_W-1:0] start_cnt, start_cnt_n;

    // Preempt only when the owner has used its quantum and someone else waits.
    assign revoke = (int'(start_cnt) >= QUANTUM) && (|(i_req & ~o_gnt));
`else
    assign revoke = 1'b0;

    // QUANTUM stays in the parameter list so both builds share one interface;
    // without preemption it has no effect.
    if (QUANTUM < 1) begin : g_quantum_unused
    end
`endif

    // Round-robin scan: first requester at or above ptr, wrapping.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && i_req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        owner_n      = owner;
        gnt_n        = o_gnt;
        busy_first_n = 1'b0;
`ifdef CIM_ARB_QUANTUM_EN
        start_cnt_n  = start_cnt;
`endif
        case (state)
            IDLE: begin
                if (found && i_cim_ready) begin
                    state_n = GRANT;
                    owner_n = winner;
                    gnt_n   = NUM_REQ'(1) << winner;
`ifdef CIM_ARB_QUANTUM_EN
                    start_cnt_n = '0;
`endif
                end
            end
            GRANT: begin
                // A start in the same cycle as a request drop keeps the grant.
                if (i_start[owner] && i_cim_ready) begin
                    state_n      = BUSY;
                    busy_first_n = 1'b1;
`ifdef CIM_ARB_QUANTUM_EN
                    if (int'(start_cnt) < QUANTUM) start_cnt_n = start_cnt + CNT_W'(1);
`endif
                end else if (!i_req[owner]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = next_idx(owner);
                end
            end
            BUSY: begin
                // The CIM lowers ready only one cycle after start, so the
                // first BUSY cycle must not treat ready as job completion.
                if (!busy_first && i_cim_ready) begin
                    if (!i_req[owner] || revoke) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        ptr_n   = next_idx(owner);
                    end else begin
                        state_n = GRANT;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            o_gnt      <= '0;
            busy_first <= 1'b0;
`ifdef CIM_ARB_QUANTUM_EN
            start_cnt  <= '0;
`endif
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            owner      <= owner_n;
            o_gnt      <= gnt_n;
            busy_first <= busy_first_n;
`ifdef CIM_ARB_QUANTUM_EN
            start_cnt  <= start_cnt_n;
`endif
        end
    end

    // Command strobes pass only in GRANT; addresses and data stay muxed
    // through BUSY so the owner can keep reading its obuf.
    always_comb begin
        o_busy          = (state != IDLE);
        o_req_ready     = (state == GRANT && i_cim_ready) ? o_gnt : '0;
        o_cim_we        = 1'b0;
        o_cim_start     = 1'b0;
        o_cim_addr      = '0;
        o_cim_data      = '0;
        o_cim_obuf_addr = '0;
        if (state == GRANT) begin
            o_cim_we    = i_we[owner] & i_cim_ready;
            o_cim_start = i_start[owner] & i_cim_ready;
        end
        if (state != IDLE) begin
            o_cim_addr      = i_addr[owner];
            o_cim_data      = i_data[owner];
            o_cim_obuf_addr = i_obuf_addr[owner];
        end
    end

endmodule
